// File: rtl/address_map_if.sv
// Bus-side signal bundle for the address decoder: the access address and controls
// go in, and the decode result and error statistics come back.
interface address_map_if #(
    parameter int ERR_CNT_W = 8
);
    logic [31:0]          input_addr;
    logic                 access_strobe;
    logic                 err_clear;
    logic [2:0]           select;
    logic [5:0]           write_enable;
    logic                 out_of_range_error;
    logic                 err_sticky;
    logic [31:0]          err_addr;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output input_addr, access_strobe, err_clear,
        input  select, write_enable, out_of_range_error, err_sticky, err_addr, err_count
    );

    modport slave (
        input  input_addr, access_strobe, err_clear,
        output select, write_enable, out_of_range_error, err_sticky, err_addr, err_count
    );
endinterface

// File: rtl/address_map.sv
// Combinational region decoder (read mux select and one-hot write permission)
// with registered out-of-range statistics: sticky flag, first bad address, saturating count.
module address_map #(
    parameter int ERR_CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    address_map_if.slave bus
);
    localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
    localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    logic [2:0]           select_s;
    logic [5:0]           write_enable_s;
    logic                 out_of_range_s;
    logic                 err_sticky_q, err_sticky_d;
    logic [31:0]          err_addr_q, err_addr_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    // Region decode: everything lives below 0x1000, split on 256-byte pages
    always_comb begin
        select_s       = 3'd6;
        write_enable_s = 6'b000000;
        out_of_range_s = 1'b1;
        if (bus.input_addr[31:12] == 20'h00000) begin
            case (bus.input_addr[11:8])
                4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
                    select_s = 3'd0; write_enable_s = 6'b000001; out_of_range_s = 1'b0;
                end
                4'h8: begin
                    select_s = 3'd1; write_enable_s = 6'b000010; out_of_range_s = 1'b0;
                end
                4'h9: begin
                    select_s = 3'd2; write_enable_s = 6'b000100; out_of_range_s = 1'b0;
                end
                4'hA: begin
                    select_s = 3'd3; write_enable_s = 6'b001000; out_of_range_s = 1'b0;
                end
                4'hB: begin
                    select_s = 3'd4; write_enable_s = 6'b010000; out_of_range_s = 1'b0;
                end
                4'hC: begin
                    select_s = 3'd5; write_enable_s = 6'b100000; out_of_range_s = 1'b0;
                end
                default: begin
                    select_s = 3'd6; write_enable_s = 6'b000000; out_of_range_s = 1'b1;
                end
            endcase
        end else begin
            select_s       = 3'd6;
            write_enable_s = 6'b000000;
            out_of_range_s = 1'b1;
        end
    end

    // Statistics next-state: clear wins over a same-cycle error event
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        err_count_d  = err_count_q;
        if (bus.err_clear) begin
            err_sticky_d = 1'b0;
            err_addr_d   = 32'h0000_0000;
            err_count_d  = {ERR_CNT_W{1'b0}};
        end else if (bus.access_strobe && out_of_range_s) begin
            err_sticky_d = 1'b1;
            if (!err_sticky_q) begin
                err_addr_d = bus.input_addr;
            end else begin
                err_addr_d = err_addr_q;
            end
            if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNT_ONE;
            end else begin
                err_count_d = err_count_q;
            end
        end else begin
            err_sticky_d = err_sticky_q;
            err_addr_d   = err_addr_q;
            err_count_d  = err_count_q;
        end
    end

    // Statistics registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= 32'h0000_0000;
            err_count_q  <= {ERR_CNT_W{1'b0}};
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
            err_count_q  <= err_count_d;
        end
    end

    assign bus.select             = select_s;
    assign bus.write_enable       = write_enable_s;
    assign bus.out_of_range_error = out_of_range_s;
    assign bus.err_sticky         = err_sticky_q;
    assign bus.err_addr           = err_addr_q;
    assign bus.err_count          = err_count_q;
endmodule

// File: tb/tb_address_map.sv
// Scoreboarded random and directed bench for address_map against a table-driven region model.
module tb_address_map;
    localparam int CW      = 8;
    localparam int CNT_MAX = 255;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  sel;
        logic [5:0]  we;
        logic        oor;
        logic        sticky;
        logic [31:0] eaddr;
        logic [7:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    address_map_if #(.ERR_CNT_W(CW)) bus_if ();

    address_map #(.ERR_CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    always #5 clk = ~clk;

    exp_t        q[$];
    int          vectors = 0;
    int          fails   = 0;
    logic [31:0] lo[6] = '{32'h000, 32'h800, 32'h900, 32'hA00, 32'hB00, 32'hC00};
    logic [31:0] hi[6] = '{32'h7FF, 32'h8FF, 32'h9FF, 32'hAFF, 32'hBFF, 32'hCFF};
    logic [31:0] edges[14] = '{32'h7FC, 32'h7FF, 32'h800, 32'h8FF, 32'h900, 32'h9FF, 32'hA00,
                               32'hAFF, 32'hB00, 32'hBFF, 32'hC00, 32'hCFF, 32'hD00, 32'hFFFFFFFF};
    logic        m_sticky = 1'b0;
    logic [31:0] m_addr   = 32'h0;
    int          m_cnt    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    // One bus cycle: drive inputs, advance the reference model, queue the expectation
    task automatic step(input logic [31:0] a, input logic stb, input logic clr, input logic r);
        exp_t e;
        @(negedge clk);
        bus_if.input_addr    = a;
        bus_if.access_strobe = stb;
        bus_if.err_clear     = clr;
        rst                  = r;
        e.a = a; e.sel = 3'd6; e.we = 6'b0; e.oor = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (a >= lo[i] && a <= hi[i]) begin
                e.sel = 3'(i); e.we = 6'(1 << i); e.oor = 1'b0;
            end
        end
        if (r || clr) begin
            m_sticky = 1'b0; m_addr = 32'h0; m_cnt = 0;
        end else if (stb && e.oor) begin
            if (!m_sticky) m_addr = a;
            m_sticky = 1'b1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        e.sticky = m_sticky; e.eaddr = m_addr; e.cnt = 8'(m_cnt);
        q.push_back(e);
    endtask

    // Monitor: after each rising edge compare DUT against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("select", 32'(bus_if.select), 32'(e.sel));
                chk("write_enable", 32'(bus_if.write_enable), 32'(e.we));
                chk("out_of_range_error", 32'(bus_if.out_of_range_error), 32'(e.oor));
                chk("err_sticky", 32'(bus_if.err_sticky), 32'(e.sticky));
                chk("err_addr", bus_if.err_addr, e.eaddr);
                chk("err_count", 32'(bus_if.err_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        logic [31:0] a;
        bus_if.input_addr    = 32'h0;
        bus_if.access_strobe = 1'b0;
        bus_if.err_clear     = 1'b0;
        step(32'h0000_0D00, 1'b1, 1'b0, 1'b1);
        step(32'h0000_0800, 1'b1, 1'b0, 1'b1);

        // Boundary sweep and alignment, mixed strobes
        step(32'h0000_07FC, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0800, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0CFF, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0D00, 1'b0, 1'b0, 1'b0);
        step(32'h0000_0902, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0900, 1'b1, 1'b0, 1'b0);

        // High addresses: first error captured, second only counted
        step(32'h8000_0000, 1'b1, 1'b0, 1'b0);
        step(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0A10, 1'b1, 1'b0, 1'b0);

        // Clear priority over a same-cycle error
        step(32'h0000_1000, 1'b1, 1'b1, 1'b0);
        step(32'h0000_0B00, 1'b0, 1'b0, 1'b0);

        // Saturation
        for (int i = 0; i < 300; i++) step(32'h0001_0000 + 32'(i), 1'b1, 1'b0, 1'b0);
        step(32'h0000_0D04, 1'b1, 1'b0, 1'b0);
        step(32'h0000_0000, 1'b1, 1'b1, 1'b0);

        // Async reset between edges after errors, then unstrobed bad address
        step(32'h0000_2000, 1'b1, 1'b0, 1'b0);
        step(32'h0000_3000, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst_sticky", 32'(bus_if.err_sticky), 32'd0);
        chk("async_rst_addr", bus_if.err_addr, 32'd0);
        chk("async_rst_count", 32'(bus_if.err_count), 32'd0);
        chk("rst_comb_select", 32'(bus_if.select), 32'd6);
        m_sticky = 1'b0; m_addr = 32'h0; m_cnt = 0;
        step(32'h0000_0C40, 1'b1, 1'b0, 1'b1);
        step(32'h0000_4000, 1'b1, 1'b0, 1'b0);
        step(32'h0000_5000, 1'b0, 1'b0, 1'b0);
        step(32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);

        // Random traffic
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 3))
                0:       a = 32'($urandom_range(0, 32'hCFF));
                1:       a = 32'h0000_0D00 + 32'($urandom_range(0, 255));
                2:       a = $urandom;
                default: a = edges[$urandom_range(0, 13)];
            endcase
            step(a, 1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0), 1'b0);
        end

        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/address_map.md
ADDRESS_MAP -- requirements
Module: address_map

Interface
REQ-001 Parameter ERR_CNT_W, default 8: width of the out-of-range error counter.
REQ-002 clk  input  1: single clock; all state updates on its rising edge.
REQ-003 rst  input  1: asynchronous, active-high reset.
REQ-004 input_addr  input  32: byte address of the current bus access.
REQ-005 access_strobe  input  1: high for one cycle per bus access; qualifies error statistics only.
REQ-006 err_clear  input  1: synchronous clear of the error statistics.
REQ-007 select  output  3: read-data mux select, combinational.
REQ-008 write_enable  output  6: one-hot per-device write permission, combinational; bit0 DM, bit1 INTC, bit2..5 FACT0..FACT3.
REQ-009 out_of_range_error  output  1: combinational; high when input_addr hits no region.
REQ-010 err_sticky  output  1: registered; set on a qualified out-of-range access.
REQ-011 err_addr  output  32: registered; address of the first qualified out-of-range access since reset or clear.
REQ-012 err_count  output  ERR_CNT_W: registered; saturating count of qualified out-of-range accesses.

Function
REQ-013 Decode is purely combinational from input_addr; it does not depend on clk, rst or access_strobe.
REQ-014 Region map (inclusive, byte addresses):
- DM 0x0000_0000-0x0000_07FF -> select 0, write_enable 6'b000001
- INTC 0x0000_0800-0x0000_08FF -> select 1, write_enable 6'b000010
- FACT0 0x0000_0900-0x0000_09FF -> select 2, write_enable 6'b000100
- FACT1 0x0000_0A00-0x0000_0AFF -> select 3, write_enable 6'b001000
- FACT2 0x0000_0B00-0x0000_0BFF -> select 4, write_enable 6'b010000
- FACT3 0x0000_0C00-0x0000_0CFF -> select 5, write_enable 6'b100000
REQ-015 Any other address (0x0000_0D00-0xFFFF_FFFF) is out of range: select 3'd6, write_enable 6'b000000, out_of_range_error 1.
REQ-016 In range: out_of_range_error 0; write_enable has exactly one bit set.
REQ-017 Low two address bits do not affect decode; unaligned addresses decode by region only.
REQ-018 write_enable is a permission only; the caller ANDs it with the processor write strobe.
REQ-019 On a rising edge with access_strobe=1 and out_of_range_error=1:
- err_sticky <= 1
- err_count increments; it saturates at all-ones and does not wrap
- err_addr <= input_addr only when err_sticky was 0 before the edge
REQ-020 err_clear=1 clears err_sticky, err_addr and err_count to 0 on the edge and takes priority over a simultaneous error event; that event is not counted.
REQ-021 access_strobe=0: statistics registers hold, whatever the address.
REQ-022 In-range strobed accesses never change the statistics registers.

Reset
REQ-023 Asserting rst immediately forces err_sticky=0, err_addr=0, err_count=0, independent of clk.
REQ-024 Combinational outputs stay valid during reset and follow input_addr.
REQ-025 Reset deasserting mid-operation: the first rising edge with rst=0 is evaluated normally.

Verification
REQ-026 Boundary sweep: 0x000007FC->sel0/we 000001; 0x00000800->sel1/we 000010; 0x00000CFF->sel5/we 100000; 0x00000D00->sel6/we 0/err 1.
REQ-027 Alignment: 0x00000902 and 0x00000900 both -> sel2, we 000100, err 0.
REQ-028 High address: 0x80000000 with strobe for one cycle -> err_sticky 1, err_addr 0x80000000, err_count 1; then 0xFFFFFFFC with strobe -> err_count 2, err_addr unchanged.
REQ-029 Saturation: 300 strobed out-of-range cycles with ERR_CNT_W=8 -> err_count 255 and stays at 255.
REQ-030 Clear priority: err_clear and a strobed out-of-range access in the same cycle -> all statistics 0 after the edge.
REQ-031 Async reset: assert rst between clock edges after errors -> statistics 0 immediately; unstrobed out-of-range address -> statistics unchanged.
